sd_cmd_ctrl: RTL and testbench

SD-bus CMD-line engine for the card-side path of the encryptor. It sits directly downstream of the SD protocol sequencer, which supplies a command index and argument plus a start pulse. The engine serialises the 48-bit command frame with CRC7, waits for and deserialises the card response, checks it, and returns a 32-bit response word with a single done pulse. Bit timing comes from an SD-clock strobe produced by the clock divider, so the engine runs entirely on the system clock.

---
 rtl/sd_cmd_ctrl.sv | 109 ++++++++++
 tb/tb_sd_cmd_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_ctrl.sv
// sd_cmd_ctrl: SD CMD-line engine that sends a CRC7 command frame and collects and checks the card response
module sd_cmd_ctrl #(
  parameter int NCR_MAX = 64,
  parameter int NRC     = 8
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istb,
  input  logic        istart,
  input  logic [5:0]  icmd_index,
  input  logic [31:0] icmd_arg,
  input  logic        icmd_sd,
  output logic        ocmd_sd,
  output logic [31:0] oresp,
  output logic        odone,
  output logic        ocrc_fail,
  output logic        otimeout
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, TAIL, DONE} state_t;
  state_t state;
  logic [5:0]   idx;
  logic [47:0]  txf;
  logic [134:0] rsh;
  logic [15:0]  cnt;
  logic         tmo;
  logic         no_resp, long_resp, no_crc, crc_bad;
  logic [39:0]  tx_body;
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = {c[5:0], 1'b0} ^ ({7{d[i] ^ c[6]}} & 7'h09);
    return c;
  endfunction
  // rsh keeps the last received bits with the newest at bit 0, so a 48-bit frame sits in rsh[47:0]
  always_comb begin
    no_resp   = idx == 6'd0 || idx == 6'd15;
    long_resp = idx == 6'd2;
    no_crc    = long_resp || idx == 6'd41;
    tx_body   = {2'b01, icmd_index, icmd_arg};
    crc_bad   = long_resp ? (!rsh[0] || rsh[134])
                          : (!rsh[0] || rsh[46] || (!no_crc && crc7(rsh[47:8]) != rsh[7:1]));
  end
  always_ff @(posedge iclk) begin
    if (irst) begin
      state     <= IDLE;
      ocmd_sd   <= 1'b1;
      oresp     <= '0;
      odone     <= 1'b0;
      ocrc_fail <= 1'b0;
      otimeout  <= 1'b0;
      idx       <= '0;
      txf       <= '1;
      rsh       <= '0;
      cnt       <= '0;
      tmo       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (istart) begin
          idx   <= icmd_index;
          txf   <= {tx_body, crc7(tx_body), 1'b1};
          rsh   <= '0;
          cnt   <= '0;
          tmo   <= 1'b0;
          state <= SEND;
        end
        SEND: if (istb) begin
          ocmd_sd <= txf[47];
          txf     <= {txf[46:0], 1'b1};
          cnt     <= cnt == 16'd47 ? 16'd0 : cnt + 16'd1;
          if (cnt == 16'd47) state <= no_resp ? TAIL : WAIT;
        end
        WAIT: if (istb) begin
          ocmd_sd <= 1'b1;
          if (!icmd_sd) begin
            rsh   <= {rsh[133:0], 1'b0};
            cnt   <= 16'd1;
            state <= RECV;
          end else if (cnt == 16'(NCR_MAX - 1)) begin
            tmo   <= 1'b1;
            cnt   <= '0;
            state <= TAIL;
          end else cnt <= cnt + 16'd1;
        end
        RECV: if (istb) begin
          rsh <= {rsh[133:0], icmd_sd};
          cnt <= cnt == (long_resp ? 16'd135 : 16'd47) ? 16'd0 : cnt + 16'd1;
          if (cnt == (long_resp ? 16'd135 : 16'd47)) state <= TAIL;
        end
        TAIL: if (istb) begin
          ocmd_sd <= 1'b1;
          if (cnt == 16'(NRC - 1)) begin
            odone     <= 1'b1;
            otimeout  <= tmo;
            ocrc_fail <= !tmo && !no_resp && crc_bad;
            if (!tmo && !no_resp) oresp <= long_resp ? rsh[31:0] : rsh[39:8];
            state     <= DONE;
          end else cnt <= cnt + 16'd1;
        end
        DONE: begin
          odone     <= 1'b0;
          ocrc_fail <= 1'b0;
          otimeout  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// tb_sd_cmd_ctrl: randomized scoreboard bench for the SD CMD-line engine with a card-side response model
module tb_sd_cmd_ctrl;
  localparam int NCR = 64;
  localparam int NRCP = 8;
  logic iclk = 0, irst = 1, istb = 0, istart = 0, icmd_sd = 1;
  logic [5:0] icmd_index = '0;
  logic [31:0] icmd_arg = '0;
  logic ocmd_sd, odone, ocrc_fail, otimeout;
  logic [31:0] oresp;
  int compared = 0, mismatched = 0, scnt = 0;
  logic [31:0] last_resp = '0;
  typedef struct {logic [31:0] resp; logic crc; logic tmo; int lat; int s0;} exp_t;
  exp_t q[$];

  sd_cmd_ctrl #(.NCR_MAX(NCR), .NRC(NRCP)) dut (
    .iclk(iclk), .irst(irst), .istb(istb), .istart(istart),
    .icmd_index(icmd_index), .icmd_arg(icmd_arg), .icmd_sd(icmd_sd),
    .ocmd_sd(ocmd_sd), .oresp(oresp), .odone(odone),
    .ocrc_fail(ocrc_fail), .otimeout(otimeout)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) if (istb) scnt <= scnt + 1;
  initial forever begin
    repeat (2) @(negedge iclk);
    istb = 1;
    @(negedge iclk);
    istb = 0;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached with %0d compared", compared);
    $fatal(1, "watchdog expired");
  end

  // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] ref_crc(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r = r ^ (47'(8'h89) << (i - 7));
    return r[6:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_s(input int t);
    int g = 0;
    while (scnt < t && g < 3000) begin
      @(negedge iclk);
      g++;
    end
    if (scnt < t) begin
      compared++;
      mismatched++;
      $display("FAIL wait_strobe: reached %0d of %0d", scnt, t);
    end
  endtask

  always @(negedge iclk) if (odone) begin
    exp_t e;
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL unexpected_done: odone=1 with no command outstanding");
    end else begin
      e = q.pop_front();
      chk("oresp", 64'(oresp), 64'(e.resp));
      chk("ocrc_fail", 64'(ocrc_fail), 64'(e.crc));
      chk("otimeout", 64'(otimeout), 64'(e.tmo));
      chk("latency_strobes", 64'(scnt - e.s0), 64'(e.lat));
    end
  end

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, output int s0);
    @(negedge iclk);
    #1;
    istart = 1;
    icmd_index = idx;
    icmd_arg = arg;
    s0 = scnt + (istb ? 1 : 0);
    @(negedge iclk);
    #1;
    istart = 0;
    icmd_index = 6'($urandom);
    icmd_arg = $urandom;
  endtask

  // k = strobes the card waits before its start bit (0 means it never answers)
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input int k, input int err,
                         input logic [31:0] pay, input logic [126:0] r2, input logic line,
                         output logic [47:0] txo);
    int s0, n, g;
    logic [47:0] exp_tx;
    logic [135:0] f;
    logic none;
    exp_t e;
    none = idx == 0 || idx == 15;
    exp_tx = {2'b01, idx, arg, ref_crc({2'b01, idx, arg}), 1'b1};
    if (idx == 2) begin
      f = {2'b00, 6'h3F, r2, 1'b1};
      n = 136;
    end else if (idx == 41) begin
      f = {88'b0, 8'h3F, pay, 8'hFF};
      n = 48;
    end else begin
      f = {88'b0, 2'b00, idx, pay, ref_crc({2'b00, idx, pay}), 1'b1};
      n = 48;
    end
    if (err == 1) f[1] = ~f[1];
    if (err == 2) f[0] = 1'b0;
    if (err == 3) f[n-2] = 1'b1;
    e.crc = 0;
    e.tmo = 0;
    e.resp = last_resp;
    if (none) e.lat = 48 + NRCP;
    else if (k == 0) begin
      e.tmo = 1;
      e.lat = 48 + NCR + NRCP;
    end else begin
      e.resp = n == 136 ? f[31:0] : f[39:8];
      e.crc = f[n-2] | ~f[0] | (idx != 2 && idx != 41 && ref_crc(f[47:8]) != f[7:1]);
      e.lat = 48 + k + n - 1 + NRCP;
    end
    last_resp = e.resp;
    issue(idx, arg, s0);
    e.s0 = s0;
    q.push_back(e);
    for (int i = 0; i < 48; i++) begin
      wait_s(s0 + i + 1);
      txo[47-i] = ocmd_sd;
      if (i == 10) begin
        istart = 1;
        icmd_index = 6'($urandom);
        @(negedge iclk);
        istart = 0;
      end
    end
    chk("tx_frame", 64'(txo), 64'(exp_tx));
    if (line && k != 1) begin
      wait_s(s0 + 49);
      chk("line_high_after_end", 64'(ocmd_sd), 64'(1));
    end
    if (!none && k > 0) begin
      for (int j = 0; j < n; j++) begin
        wait_s(s0 + 48 + k - 1 + j);
        icmd_sd = f[n-1-j];
      end
      wait_s(s0 + 48 + k + n - 1);
      icmd_sd = 1;
    end
    g = 0;
    while (q.size() != 0 && g < 5000) begin
      @(negedge iclk);
      g++;
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_wait: no odone within %0d cycles", g);
      q.delete();
    end
    repeat (3) @(negedge iclk);
  endtask

  initial begin
    logic [47:0] txo;
    logic [126:0] r2;
    logic [5:0] idx;
    int s0, k, err;
    repeat (3) @(negedge iclk);
    chk("rst_ocmd_sd", 64'(ocmd_sd), 64'(1));
    chk("rst_oresp", 64'(oresp), 64'(0));
    chk("rst_odone", 64'(odone), 64'(0));
    chk("rst_ocrc_fail", 64'(ocrc_fail), 64'(0));
    chk("rst_otimeout", 64'(otimeout), 64'(0));
    irst = 0;
    repeat (4) @(negedge iclk);
    r2 = 127'({$urandom, $urandom, $urandom, $urandom});
    run_cmd(6'd55, 32'h0, 3, 0, $urandom, r2, 1, txo);
    chk("cmd55_frame", 64'(txo), 64'h77_0000_0000_65);
    run_cmd(6'd17, 32'h200, 5, 0, 32'h900, r2, 1, txo);
    run_cmd(6'd17, 32'h200, 5, 1, 32'h900, r2, 1, txo);
    run_cmd(6'd41, 32'h80300000, 7, 0, 32'h80FF8000, r2, 1, txo);
    run_cmd(6'd15, $urandom, 0, 0, 32'h0, r2, 1, txo);
    run_cmd(6'd7, $urandom, 0, 0, 32'h0, r2, 1, txo);
    run_cmd(6'd2, $urandom, 9, 0, 32'h0, r2, 1, txo);
    issue(6'd7, 32'h0, s0);
    wait_s(s0 + 20);
    chk("pre_rst_line", 64'(ocmd_sd), 64'(0));
    irst = 1;
    @(negedge iclk);
    chk("midcmd_rst_line", 64'(ocmd_sd), 64'(1));
    chk("midcmd_rst_odone", 64'(odone), 64'(0));
    chk("midcmd_rst_oresp", 64'(oresp), 64'(0));
    irst = 0;
    last_resp = '0;
    repeat (400) @(negedge iclk);
    run_cmd(6'd7, 32'h12340000, 4, 0, $urandom, r2, 1, txo);
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 5))
        0: idx = 6'd2;
        1: idx = 6'd41;
        2: idx = 6'd15;
        3: idx = 6'd0;
        default: idx = 6'($urandom_range(0, 63));
      endcase
      k = $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, NCR);
      err = $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 3);
      r2 = 127'({$urandom, $urandom, $urandom, $urandom});
      run_cmd(idx, $urandom, k, err, $urandom, r2, 1, txo);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
